// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use, redirect, MDU and data-memory waits, MDU watchdog.
// Optional stall/flush statistics counters when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_use,
  input  logic       i_id_rs2_use,
  input  logic       i_id_valid,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_is_load,
  input  logic       i_ex_redirect,
  input  logic       i_ex_mdu_start,
  input  logic       i_mdu_done,
  input  logic       i_mem_req,
  input  logic       i_mem_ack,
  output logic       o_pc_stall,
  output logic       o_if_id_stall,
  output logic       o_if_id_flush,
  output logic       o_id_ex_stall,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_stall,
  output logic       o_redirect_take,
  output logic [1:0] o_state,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
`endif
  output logic       o_mdu_err
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MDU_WAIT = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  localparam int WD_W = $clog2(MDU_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic load_use, mem_wait;
  logic pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, redir;

  assign load_use = i_id_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                    ((i_id_rs1_use & (i_id_rs1 == i_ex_rd)) |
                     (i_id_rs2_use & (i_id_rs2 == i_ex_rd)));
  assign mem_wait = i_mem_req & ~i_mem_ack;

  always_comb begin
    pc_st    = 1'b0;
    ifid_st  = 1'b0;
    ifid_fl  = 1'b0;
    idex_st  = 1'b0;
    idex_fl  = 1'b0;
    exmem_st = 1'b0;
    redir    = 1'b0;
    state_d  = state_q;
    wd_d     = wd_q;
    err_d    = err_q;
    if (!i_reset) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (mem_wait) begin
            {pc_st, ifid_st, idex_st, exmem_st} = 4'b1111;
            state_d = S_MEM_WAIT;
          end else if (i_ex_redirect) begin
            // ID instruction is squashed, so a coincident load-use is moot
            {redir, ifid_fl, idex_fl} = 3'b111;
          end else if (i_ex_mdu_start) begin
            {pc_st, ifid_st, idex_st} = 3'b111;
            state_d = S_MDU_WAIT;
            wd_d    = '0;
          end else if (load_use) begin
            {pc_st, ifid_st, idex_fl} = 3'b111;
          end
        end
        S_MDU_WAIT: begin
          if (i_mdu_done) begin
            if (mem_wait) begin
              {pc_st, ifid_st, idex_st, exmem_st} = 4'b1111;
              state_d = S_MEM_WAIT;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            // EX/MEM keeps loading so MEM sees bubbles while EX is held
            {pc_st, ifid_st, idex_st} = 3'b111;
            wd_d = wd_q + WD_W'(1);
            if (wd_q == WD_LAST) begin
              err_d   = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_MEM_WAIT: begin
          // Redirect stays held in EX and is taken once back in RUN
          if (mem_wait) {pc_st, ifid_st, idex_st, exmem_st} = 4'b1111;
          else          state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign o_pc_stall      = pc_st;
  assign o_if_id_flush   = ifid_fl;
  assign o_if_id_stall   = ifid_st & ~ifid_fl;
  assign o_id_ex_flush   = idex_fl;
  assign o_id_ex_stall   = idex_st & ~idex_fl;
  assign o_ex_mem_stall  = exmem_st;
  assign o_redirect_take = redir;
  assign o_state         = state_q;
  assign o_mdu_err       = err_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_st && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RUN-state vector table plus multi-cycle sequences.
module tb_hazard_ctrl;
  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
  logic       i_id_rs1_use, i_id_rs2_use, i_id_valid, i_ex_is_load;
  logic       i_ex_redirect, i_ex_mdu_start, i_mdu_done, i_mem_req, i_mem_ack;
  logic       o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall;
  logic       o_id_ex_flush, o_ex_mem_stall, o_redirect_take, o_mdu_err;
  logic [1:0] o_state;
`ifdef HAZARD_STATS_EN
  logic [31:0] o_stall_cycles, o_flush_count;
`endif

  hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_use(i_id_rs1_use), .i_id_rs2_use(i_id_rs2_use),
    .i_id_valid(i_id_valid), .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load),
    .i_ex_redirect(i_ex_redirect), .i_ex_mdu_start(i_ex_mdu_start),
    .i_mdu_done(i_mdu_done), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
    .o_pc_stall(o_pc_stall), .o_if_id_stall(o_if_id_stall),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_stall(o_id_ex_stall),
    .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_stall(o_ex_mem_stall),
    .o_redirect_take(o_redirect_take), .o_state(o_state),
`ifdef HAZARD_STATS_EN
    .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count),
`endif
    .o_mdu_err(o_mdu_err)
  );

  always #5 i_clk = ~i_clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect_take}
  logic [6:0] outs;
  assign outs = {o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
                 o_id_ex_flush, o_ex_mem_stall, o_redirect_take};

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_REDIR = 7'b0010101;
  localparam logic [6:0] O_MDU   = 7'b1101000;
  localparam logic [6:0] O_ALL   = 7'b1101010;
  localparam logic [6:0] O_RST   = 7'b0010100;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_use, rs2_use, id_valid, is_load, redirect, mem_req, mem_ack;
    logic [6:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0;
    i_id_rs1_use = 0; i_id_rs2_use = 0; i_id_valid = 0; i_ex_is_load = 0;
    i_ex_redirect = 0; i_ex_mdu_start = 0; i_mdu_done = 0; i_mem_req = 0; i_mem_ack = 0;
  endtask

  // inputs change 1 time unit after posedge; outputs checked at negedge
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic at_neg();
    @(negedge i_clk);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE});
    vecs.push_back('{"lu_rs1",      5, 1, 5, 1, 1, 1, 1, 0, 0, 0, O_LU});
    vecs.push_back('{"lu_rs2",      2, 7, 7, 1, 1, 1, 1, 0, 0, 0, O_LU});
    vecs.push_back('{"lu_rd_x0",    0, 0, 0, 1, 1, 1, 1, 0, 0, 0, O_NONE});
    vecs.push_back('{"lu_no_use",   5, 5, 5, 0, 0, 1, 1, 0, 0, 0, O_NONE});
    vecs.push_back('{"lu_id_inv",   5, 1, 5, 1, 1, 0, 1, 0, 0, 0, O_NONE});
    vecs.push_back('{"lu_not_load", 5, 1, 5, 1, 1, 1, 0, 0, 0, 0, O_NONE});
    vecs.push_back('{"lu_rs2_only", 5, 3, 5, 0, 1, 1, 1, 0, 0, 0, O_NONE});
    vecs.push_back('{"redir_lu",    5, 1, 5, 1, 1, 1, 1, 1, 0, 0, O_REDIR});
    vecs.push_back('{"redir_only",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_REDIR});
    vecs.push_back('{"mem_ack_lu",  5, 1, 5, 1, 1, 1, 1, 0, 1, 1, O_LU});
    vecs.push_back('{"ack_no_req",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE});

    idle_inputs();
    i_reset = 1'b0;
    at_neg();
    chk("reset_outs", 32'(outs), 32'(O_RST));
    tick();
    at_neg();
    chk("reset_state", 32'(o_state), 0);
    chk("reset_err", 32'(o_mdu_err), 0);
    tick();
    i_reset = 1'b1;

    // RUN-state combinational table
    foreach (vecs[k]) begin
      i_id_rs1 = vecs[k].rs1; i_id_rs2 = vecs[k].rs2; i_ex_rd = vecs[k].rd;
      i_id_rs1_use = vecs[k].rs1_use; i_id_rs2_use = vecs[k].rs2_use;
      i_id_valid = vecs[k].id_valid; i_ex_is_load = vecs[k].is_load;
      i_ex_redirect = vecs[k].redirect; i_mem_req = vecs[k].mem_req; i_mem_ack = vecs[k].mem_ack;
      at_neg();
      chk(vecs[k].name, 32'(outs), 32'(vecs[k].exp));
      tick();
      chk({vecs[k].name, "_state"}, 32'(o_state), 0);
    end
    idle_inputs();

    // Load-use: one bubble, then EX holds the bubble and everything releases
    i_id_valid = 1; i_ex_is_load = 1; i_ex_rd = 5; i_id_rs1 = 5; i_id_rs1_use = 1; i_id_rs2 = 1; i_id_rs2_use = 1;
    at_neg(); chk("lu_seq_bubble", 32'(outs), 32'(O_LU));
    tick(); i_ex_is_load = 0; i_ex_rd = 0;
    at_neg(); chk("lu_seq_release", 32'(outs), 32'(O_NONE));
    tick(); idle_inputs();

    // MDU: start, done five cycles later; redirect ignored inside the wait
    i_ex_mdu_start = 1;
    at_neg(); chk("mdu_start_outs", 32'(outs), 32'(O_MDU));
    tick(); i_ex_mdu_start = 0;
    for (int c = 1; c <= 4; c++) begin
      i_ex_redirect = (c == 2);
      at_neg();
      chk($sformatf("mdu_wait%0d_state", c), 32'(o_state), 1);
      chk($sformatf("mdu_wait%0d_outs", c), 32'(outs), 32'(O_MDU));
      tick();
    end
    i_ex_redirect = 0; i_mdu_done = 1;
    at_neg();
    chk("mdu_done_state", 32'(o_state), 1);
    chk("mdu_done_outs", 32'(outs), 32'(O_NONE));
    tick(); i_mdu_done = 0;
    at_neg(); chk("mdu_after_state", 32'(o_state), 0);
    tick();

    // MEM_WAIT with a held redirect: ack on the 4th cycle, redirect taken after
    i_mem_req = 1; i_ex_redirect = 1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk($sformatf("mem_wait%0d_outs", c), 32'(outs), 32'(O_ALL));
      chk($sformatf("mem_wait%0d_state", c), 32'(o_state), (c == 0) ? 0 : 2);
      tick();
    end
    i_mem_ack = 1;
    at_neg();
    chk("mem_ack_outs", 32'(outs), 32'(O_NONE));
    chk("mem_ack_state", 32'(o_state), 2);
    tick(); i_mem_req = 0; i_mem_ack = 0;
    at_neg();
    chk("mem_redir_state", 32'(o_state), 0);
    chk("mem_redir_outs", 32'(outs), 32'(O_REDIR));
    tick(); idle_inputs();

    // done coinciding with a memory wait hands over to MEM_WAIT
    i_ex_mdu_start = 1; tick(); i_ex_mdu_start = 0;
    i_mdu_done = 1; i_mem_req = 1;
    at_neg(); chk("done_mem_outs", 32'(outs), 32'(O_ALL));
    tick(); i_mdu_done = 0;
    at_neg(); chk("done_mem_state", 32'(o_state), 2);
    tick(); i_mem_ack = 1;
    at_neg(); chk("done_mem_ack_outs", 32'(outs), 32'(O_NONE));
    tick(); idle_inputs();
    at_neg(); chk("done_mem_run", 32'(o_state), 0);
    tick();

    // Watchdog with MDU_TIMEOUT=8: eight wait cycles, then RUN with sticky err
    i_ex_mdu_start = 1; tick(); i_ex_mdu_start = 0;
    for (int c = 1; c <= 8; c++) begin
      at_neg();
      chk($sformatf("wd%0d_state", c), 32'(o_state), 1);
      chk($sformatf("wd%0d_err", c), 32'(o_mdu_err), 0);
      tick();
    end
    at_neg();
    chk("wd_timeout_state", 32'(o_state), 0);
    chk("wd_timeout_err", 32'(o_mdu_err), 1);
    chk("wd_timeout_outs", 32'(outs), 32'(O_NONE));
    tick(); tick(); tick();
    at_neg(); chk("wd_err_sticky", 32'(o_mdu_err), 1);
    tick();

    // Reset asserted mid MDU_WAIT
    i_ex_mdu_start = 1; tick(); i_ex_mdu_start = 0;
    tick();
    at_neg(); chk("rst_mid_pre_state", 32'(o_state), 1);
    tick(); i_reset = 0;
    at_neg(); chk("rst_mid_outs", 32'(outs), 32'(O_RST));
    tick();
    at_neg();
    chk("rst_mid_state", 32'(o_state), 0);
    chk("rst_mid_err", 32'(o_mdu_err), 0);
    chk("rst_mid_outs2", 32'(outs), 32'(O_RST));
    tick(); i_reset = 1;
    at_neg(); chk("rst_release_outs", 32'(outs), 32'(O_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
